mem_port_sched: RTL and testbench

Serialises the two per-instruction memory requests issued by the Control FSM (port 1 = MemDst1/MemRead1/MemWrite1 path, port 2 = MemDst2/MemRead2/MemWrite2 path) onto a single-ported synchronous RAM. It captures both requests on a Start pulse and performs the port 1 access before the port 2 access. It returns read data per port and holds Busy high so Control stalls until Done. It sits between Control/stack-pointer datapath and the main memory block.

---
 rtl/mem_port_sched_if.sv | 36 +++
 rtl/mem_port_sched.sv | 139 +++++++++++++
 tb/tb_mem_port_sched.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sched_if.sv
// Request/response bundle between Control, the port scheduler and the main RAM.
// The master side owns the requests and the RAM read data; the slave side is the scheduler.
interface mem_port_sched_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              Start;
    logic              Rd1;
    logic              Wr1;
    logic [ADDR_W-1:0] Addr1;
    logic [DATA_W-1:0] WData1;
    logic              Rd2;
    logic              Wr2;
    logic [ADDR_W-1:0] Addr2;
    logic [DATA_W-1:0] WData2;
    logic [DATA_W-1:0] MemRData;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemWE;
    logic              MemRE;
    logic [DATA_W-1:0] RData1;
    logic [DATA_W-1:0] RData2;
    logic              Busy;
    logic              Done;
    logic              Err;

    modport master (
        output Start, Rd1, Wr1, Addr1, WData1, Rd2, Wr2, Addr2, WData2, MemRData,
        input  MemAddr, MemWData, MemWE, MemRE, RData1, RData2, Busy, Done, Err
    );

    modport slave (
        input  Start, Rd1, Wr1, Addr1, WData1, Rd2, Wr2, Addr2, WData2, MemRData,
        output MemAddr, MemWData, MemWE, MemRE, RData1, RData2, Busy, Done, Err
    );
endinterface

// File: rtl/mem_port_sched.sv
// Serialises the two per-instruction memory requests onto one synchronous RAM port.
// Port 1 always commits before port 2; RAM read data is captured one cycle after MemRE.
module mem_port_sched #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic            CLK,
    input  logic            Rst_n,
    mem_port_sched_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StAcc1, StAcc2, StTail, StDone} stateT;

    stateT             state;
    logic              rd1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wData1;
    logic              rd2;
    logic              wr2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wData2;
    logic              errFlag;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memWE;
    logic              memRE;
    logic [DATA_W-1:0] rData1;
    logic [DATA_W-1:0] rData2;
    logic              pending;
    logic              pendPort;

    logic act1;
    logic act2;
    logic reqAct1;
    logic reqAct2;
    logic reqIllegal;

    // A port is active only when exactly one of Rd/Wr is set.
    assign act1       = rd1 ^ wr1;
    assign act2       = rd2 ^ wr2;
    assign reqAct1    = bus.Rd1 ^ bus.Wr1;
    assign reqAct2    = bus.Rd2 ^ bus.Wr2;
    assign reqIllegal = (bus.Rd1 & bus.Wr1) | (bus.Rd2 & bus.Wr2);

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= StIdle;
            rd1      <= 1'b0;
            wr1      <= 1'b0;
            addr1    <= '0;
            wData1   <= '0;
            rd2      <= 1'b0;
            wr2      <= 1'b0;
            addr2    <= '0;
            wData2   <= '0;
            errFlag  <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            memWE    <= 1'b0;
            memRE    <= 1'b0;
            rData1   <= '0;
            rData2   <= '0;
            pending  <= 1'b0;
            pendPort <= 1'b0;
        end else begin
            memWE <= 1'b0;
            memRE <= 1'b0;

            // The read issued this cycle returns data next cycle; remember which port owns it.
            pending  <= memRE;
            pendPort <= (state == StAcc2);
            if (pending) begin
                if (pendPort) begin
                    rData2 <= bus.MemRData;
                end else begin
                    rData1 <= bus.MemRData;
                end
            end

            unique case (state)
                StIdle: begin
                    if (bus.Start) begin
                        rd1     <= bus.Rd1;
                        wr1     <= bus.Wr1;
                        addr1   <= bus.Addr1;
                        wData1  <= bus.WData1;
                        rd2     <= bus.Rd2;
                        wr2     <= bus.Wr2;
                        addr2   <= bus.Addr2;
                        wData2  <= bus.WData2;
                        errFlag <= reqIllegal;
                        if (reqAct1) begin
                            state    <= StAcc1;
                            memAddr  <= bus.Addr1;
                            memWData <= bus.WData1;
                            memWE    <= bus.Wr1;
                            memRE    <= bus.Rd1;
                        end else if (reqAct2) begin
                            state    <= StAcc2;
                            memAddr  <= bus.Addr2;
                            memWData <= bus.WData2;
                            memWE    <= bus.Wr2;
                            memRE    <= bus.Rd2;
                        end else begin
                            state <= StDone;
                        end
                    end
                end
                StAcc1: begin
                    if (act2) begin
                        state    <= StAcc2;
                        memAddr  <= addr2;
                        memWData <= wData2;
                        memWE    <= wr2;
                        memRE    <= rd2;
                    end else if (rd1) begin
                        state <= StTail;
                    end else begin
                        state <= StDone;
                    end
                end
                StAcc2: state <= rd2 ? StTail : StDone;
                StTail: state <= StDone;
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.MemAddr  = memAddr;
    assign bus.MemWData = memWData;
    assign bus.MemWE    = memWE;
    assign bus.MemRE    = memRE;
    assign bus.RData1   = rData1;
    assign bus.RData2   = rData2;
    assign bus.Busy     = (state != StIdle);
    assign bus.Done     = (state == StDone);
    assign bus.Err      = (state == StDone) & errFlag;
endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: directed vector table, hand-written corner sequences, and
// randomized requests checked against a transaction-level memory model.
module tb_mem_port_sched;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic CLK   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 CLK = ~CLK;

    mem_port_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK  (CLK),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    // Synchronous single-port RAM with a bench-side preload path.
    logic [DW-1:0] ram [0:65535];
    logic [DW-1:0] ramRData;
    logic          pokeEn   = 1'b0;
    logic [AW-1:0] pokeAddr = '0;
    logic [DW-1:0] pokeData = '0;

    always @(posedge CLK) begin
        if (pokeEn) ram[pokeAddr] <= pokeData;
        else if (bus.MemWE) ram[bus.MemAddr] <= bus.MemWData;
        if (bus.MemRE) ramRData <= ram[bus.MemAddr];
    end
    assign bus.MemRData = ramRData;

    // Reference model state: memory image and the last value each port read.
    logic [DW-1:0] refMem [0:65535];
    logic [DW-1:0] mR1 = '0;
    logic [DW-1:0] mR2 = '0;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic          r1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r2;
        logic          w2;
        logic [AW-1:0] a2;
        logic [DW-1:0] d2;
        int            lat;
        logic          err;
        logic [DW-1:0] x1;
        logic [DW-1:0] x2;
    } vecT;

    vecT vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        refMem[a] = d;
        @(negedge CLK);
        pokeEn = 1'b0;
    endtask

    task automatic driveReq(input logic r1, input logic w1, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d1, input logic r2, input logic w2,
                            input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        bus.Rd1    = r1;
        bus.Wr1    = w1;
        bus.Addr1  = a1;
        bus.WData1 = d1;
        bus.Rd2    = r2;
        bus.Wr2    = w2;
        bus.Addr2  = a2;
        bus.WData2 = d2;
    endtask

    task automatic scramble();
        driveReq(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // One full transaction; extraAt > 0 pulses a stray Start in that busy cycle.
    task automatic runOp(input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic r2, input logic w2,
                         input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                         input int extraAt, output int lat, output logic errSeen);
        int   nWr;
        int   nRd;
        int   expLat;
        int   busyLow;
        int   weCnt;
        int   reCnt;
        logic lastRead;
        logic seen;
        logic ill;

        // Model: port 1 then port 2 applied to the memory image, one cycle per access,
        // one extra cycle if the last access is a read, plus the Done cycle.
        nWr      = 0;
        nRd      = 0;
        lastRead = 1'b0;
        ill      = (r1 & w1) | (r2 & w2);
        if (r1 ^ w1) begin
            if (w1) begin refMem[a1] = d1; nWr++; lastRead = 1'b0; end
            else begin mR1 = refMem[a1]; nRd++; lastRead = 1'b1; end
        end
        if (r2 ^ w2) begin
            if (w2) begin refMem[a2] = d2; nWr++; lastRead = 1'b0; end
            else begin mR2 = refMem[a2]; nRd++; lastRead = 1'b1; end
        end
        expLat = (nWr + nRd == 0) ? 1 : nWr + nRd + int'(lastRead) + 1;

        @(negedge CLK);
        bus.Start = 1'b1;
        driveReq(r1, w1, a1, d1, r2, w2, a2, d2);
        @(posedge CLK);
        @(negedge CLK);
        bus.Start = 1'b0;
        scramble();

        lat     = 0;
        errSeen = 1'b0;
        seen    = 1'b0;
        busyLow = 0;
        weCnt   = 0;
        reCnt   = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            bus.Start = 1'b0;
            if (!bus.Busy) busyLow++;
            if (bus.MemWE) weCnt++;
            if (bus.MemRE) reCnt++;
            if (bus.Done) begin
                lat     = cyc;
                errSeen = bus.Err;
                seen    = 1'b1;
                break;
            end
            if (cyc == extraAt) begin
                bus.Start = 1'b1;
                scramble();
            end
            @(negedge CLK);
        end

        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(expLat));
        check("err", 32'(errSeen), 32'(ill));
        check("busy_low_cycles", 32'(busyLow), 32'd0);
        check("write_cycles", 32'(weCnt), 32'(nWr));
        check("read_cycles", 32'(reCnt), 32'(nRd));

        @(negedge CLK);
        bus.Start = 1'b0;
        check("done_one_cycle", 32'(bus.Done), 32'd0);
        check("busy_after_done", 32'(bus.Busy), 32'd0);
        check("rdata1", 32'(bus.RData1), 32'(mR1));
        check("rdata2", 32'(bus.RData2), 32'(mR2));
        check("ram_addr1", 32'(ram[a1]), 32'(refMem[a1]));
        check("ram_addr2", 32'(ram[a2]), 32'(refMem[a2]));
    endtask

    initial begin
        int   lat;
        int   doneCnt;
        logic errSeen;

        bus.Start = 1'b0;
        driveReq(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

        vecs[0] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0000,
                    4, 1'b0, 16'hAAAA, 16'h5555};
        vecs[1] = '{1'b0, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h0030, 16'h0000,
                    4, 1'b0, 16'hAAAA, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'hBEEF,
                    2, 1'b0, 16'hAAAA, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 16'h0050, 16'h9999, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1, 1'b1, 16'hAAAA, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1, 1'b0, 16'hAAAA, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h7777,
                    3, 1'b0, 16'hBEEF, 16'h1234};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000,
                    3, 1'b0, 16'hBEEF, 16'h7777};
        vecs[7] = '{1'b0, 1'b1, 16'h0060, 16'h0101, 1'b1, 1'b1, 16'h0050, 16'h4444,
                    2, 1'b1, 16'hBEEF, 16'h7777};

        // Reset values.
        repeat (2) @(negedge CLK);
        check("rst_memaddr", 32'(bus.MemAddr), 32'd0);
        check("rst_memwdata", 32'(bus.MemWData), 32'd0);
        check("rst_memwe", 32'(bus.MemWE), 32'd0);
        check("rst_memre", 32'(bus.MemRE), 32'd0);
        check("rst_rdata1", 32'(bus.RData1), 32'd0);
        check("rst_rdata2", 32'(bus.RData2), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_err", 32'(bus.Err), 32'd0);
        Rst_n = 1'b1;

        poke(16'h0010, 16'hCAFD);
        poke(16'h0011, 16'hCAFE);
        poke(16'h0020, 16'hAAAA);
        poke(16'h0021, 16'h5555);
        poke(16'h0030, 16'h0000);
        poke(16'h0040, 16'h0000);
        poke(16'h0050, 16'h5050);
        poke(16'h0060, 16'h0000);
        for (int i = 0; i < 8; i++) poke(16'h0100 + 16'(i), 16'($urandom));

        // Reset in the middle of the ACC1 cycle aborts the whole sequence.
        @(negedge CLK);
        bus.Start = 1'b1;
        driveReq(1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, 1'b1, 16'h0011, 16'h2222);
        @(posedge CLK);
        @(negedge CLK);
        bus.Start = 1'b0;
        check("midrst_acc1_we", 32'(bus.MemWE), 32'd1);
        check("midrst_acc1_addr", 32'(bus.MemAddr), 32'h0010);
        #2 Rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(bus.MemWE), 32'd0);
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        check("midrst_done", 32'(bus.Done), 32'd0);
        check("midrst_addr", 32'(bus.MemAddr), 32'd0);
        @(negedge CLK);
        Rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.Done) doneCnt++;
            @(negedge CLK);
        end
        check("midrst_no_done", 32'(doneCnt), 32'd0);
        check("midrst_ram10", 32'(ram[16'h0010]), 32'hCAFD);
        check("midrst_ram11", 32'(ram[16'h0011]), 32'hCAFE);
        mR1 = '0;
        mR2 = '0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1,
                  vecs[i].r2, vecs[i].w2, vecs[i].a2, vecs[i].d2, 0, lat, errSeen);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_err", i), 32'(errSeen), 32'(vecs[i].err));
            check($sformatf("vec%0d_rdata1", i), 32'(bus.RData1), 32'(vecs[i].x1));
            check($sformatf("vec%0d_rdata2", i), 32'(bus.RData2), 32'(vecs[i].x2));
        end
        check("illegal_ram50", 32'(ram[16'h0050]), 32'h5050);

        // Start pulsed during ACC2 must be ignored entirely.
        runOp(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0000, 2, lat, errSeen);
        check("busy_start_rdata1", 32'(bus.RData1), 32'hAAAA);
        check("busy_start_rdata2", 32'(bus.RData2), 32'h5555);
        doneCnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.Done || bus.Busy) doneCnt++;
            @(negedge CLK);
        end
        check("busy_start_not_queued", 32'(doneCnt), 32'd0);

        // Randomized requests over a small address window to provoke hazards.
        for (int i = 0; i < 40; i++) begin
            logic r1;
            logic w1;
            logic r2;
            logic w2;
            r1 = 1'($urandom);
            w1 = 1'($urandom);
            r2 = 1'($urandom);
            w2 = 1'($urandom);
            runOp(r1, w1, 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom),
                  r2, w2, 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom),
                  int'($urandom_range(0, 4)), lat, errSeen);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
